// File: rtl/mem_req_arbiter.sv
// Two-requester burst arbiter sharing one memory port between I-side and D-side fill engines.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin tie-break (default: D-side fixed priority).
module mem_req_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_rvalid,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_wnext,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_rvalid,
   output logic              d_done,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic [ADDR_W-1:0] mem_cmd_addr,
   output logic              mem_cmd_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wvalid,
   input  logic              mem_wready,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic              stall
);
   localparam int CNT_W = $clog2(BURST_LEN) + 1;
   localparam int OFF_W = $clog2(BURST_LEN) + 2;
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

   typedef enum logic [2:0] {IDLE, CMD, WBEAT, RBEAT, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             own_q, own_d;   // 1 = D-side owns the port
   logic             grant_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   // On a tie the side that did not win last time goes first.
   always_comb begin
      grant_d = d_req & (~i_req | ~last_q);
      last_d  = last_q;
      if (state_q == IDLE && (i_req | d_req)) begin
         last_d = grant_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b0;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      grant_d = d_req;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         own_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         own_q   <= own_d;
      end
   end

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      own_d         = own_q;
      mem_cmd_valid = 1'b0;
      mem_cmd_addr  = '0;
      mem_cmd_we    = 1'b0;
      mem_wvalid    = 1'b0;
      mem_wdata     = '0;
      d_wnext       = 1'b0;
      i_rvalid      = 1'b0;
      d_rvalid      = 1'b0;
      i_done        = 1'b0;
      d_done        = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req | d_req) begin
               own_d   = grant_d;
               cnt_d   = '0;
               state_d = CMD;
            end
         end
         CMD: begin
            mem_cmd_valid = 1'b1;
            mem_cmd_addr  = (own_q ? d_addr : i_addr) & LINE_MASK;
            mem_cmd_we    = own_q & d_we;
            if (mem_cmd_ready) begin
               state_d = (own_q & d_we) ? WBEAT : RBEAT;
            end
         end
         WBEAT: begin
            mem_wvalid = 1'b1;
            mem_wdata  = d_wdata;
            if (mem_wready) begin
               d_wnext = 1'b1;
               cnt_d   = cnt_inc;
               if (cnt_inc == LAST_BEAT) begin
                  state_d = DONE;
               end
            end
         end
         RBEAT: begin
            // Read beats are forwarded in the same cycle they arrive.
            if (mem_rvalid) begin
               i_rvalid = ~own_q;
               d_rvalid = own_q;
               cnt_d    = cnt_inc;
               if (cnt_inc == LAST_BEAT) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            i_done  = ~own_q;
            d_done  = own_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;
   assign stall   = (i_req & ~i_done) | (d_req & ~d_done);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: a transaction-level model predicts the event stream
// (command, beats, done) and a monitor consumes it as the DUT presents outputs.
module tb_mem_req_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BL = 4;
   localparam int KIND_CMD  = 0;
   localparam int KIND_RB   = 1;
   localparam int KIND_WB   = 2;
   localparam int KIND_DONE = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, d_req, d_we;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] i_rdata, d_rdata;
   logic          i_rvalid, i_done, d_wnext, d_rvalid, d_done;
   logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
   logic [AW-1:0] mem_cmd_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_wvalid, mem_wready, mem_rvalid;
   logic          stall;

   always #5 clk = ~clk;

   mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
      .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
      .mem_cmd_we(mem_cmd_we), .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid),
      .mem_wready(mem_wready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .stall(stall)
   );

   typedef struct {
      int          kind;
      bit          side;   // 1 = D
      logic [31:0] val;
      bit          we;
   } ev_t;

   ev_t         sb[$];
   int          checks = 0;
   int          errors = 0;
   bit          last_grant;     // model: side granted most recently (1 = D)
   logic [31:0] rd_xor;
   int          cmd_hold;
   bit          rnd_mode, wr_toggle;
   int          stray_en;
   logic [31:0] i_addr_a [0:7];
   logic [31:0] d_addr_a [0:7];
   bit          d_we_a   [0:7];
   logic [31:0] d_wd_a   [0:7][0:BL-1];

   function automatic logic [31:0] rd_word(input logic [31:0] line, input int idx);
      return (line ^ rd_xor) + 32'(idx);
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, got, req);
      end
   endtask

   task automatic pop_cmp(input int k, input bit s, input logic [31:0] v, input string nm);
      ev_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: got unexpected event data=%h, required no event", nm, v);
      end else begin
         e = sb.pop_front();
         if (e.kind != k || e.side != s || e.val !== v) begin
            errors++;
            $display("FAIL %s: got kind=%0d side=%0d data=%h, required kind=%0d side=%0d data=%h",
                     nm, k, s, v, e.kind, e.side, e.val);
         end
      end
   endtask

   // Monitor: consumes expected events as the DUT presents them.
   always @(negedge clk) begin
      if (!rst) begin
         chk("stall", stall, (i_req & ~i_done) | (d_req & ~d_done));
         chk("wnext_align", d_wnext, mem_wvalid & mem_wready);
         if (mem_cmd_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL cmd: got unexpected command addr=%h, required none", mem_cmd_addr);
            end else if (sb[0].kind != KIND_CMD || sb[0].val !== mem_cmd_addr || sb[0].we != mem_cmd_we) begin
               errors++;
               $display("FAIL cmd: got addr=%h we=%0d, required kind=%0d addr=%h we=%0d",
                        mem_cmd_addr, mem_cmd_we, sb[0].kind, sb[0].val, sb[0].we);
            end
            if (mem_cmd_ready && sb.size() > 0) void'(sb.pop_front());
         end
         if (i_rvalid) pop_cmp(KIND_RB, 1'b0, i_rdata, "i_rbeat");
         if (d_rvalid) pop_cmp(KIND_RB, 1'b1, d_rdata, "d_rbeat");
         if (mem_wvalid && mem_wready) pop_cmp(KIND_WB, 1'b1, mem_wdata, "wbeat");
         if (i_done) pop_cmp(KIND_DONE, 1'b0, 32'h0, "i_done");
         if (d_done) pop_cmp(KIND_DONE, 1'b1, 32'h0, "d_done");
      end
   end

   // Memory responder: in-order bursts, configurable handshake behaviour.
   initial begin
      int          ph;
      int          bidx;
      logic [31:0] line;
      bit          wtog;
      ph = 0; bidx = 0; line = '0; wtog = 1'b0;
      mem_cmd_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ph = 0;
         end else begin
            if (ph == 1 && mem_rvalid) begin
               bidx++;
               if (bidx == BL) ph = 0;
            end else if (ph == 2 && mem_wvalid && mem_wready) begin
               bidx++;
               if (bidx == BL) ph = 0;
            end
            if (mem_cmd_valid && mem_cmd_ready) begin
               ph   = mem_cmd_we ? 2 : 1;
               line = mem_cmd_addr;
               bidx = 0;
               wtog = 1'b1;
            end
         end
         @(posedge clk);
         #2;
         if (cmd_hold > 0) begin
            mem_cmd_ready = 1'b0;
            if (mem_cmd_valid) cmd_hold--;
         end else begin
            mem_cmd_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (!rst && ph == 1) begin
            if (!rnd_mode || $urandom_range(0, 1) == 1) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rd_word(line, bidx);
            end
         end else if (!rst && (stray_en == 2 || (stray_en == 1 && $urandom_range(0, 2) == 0))) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_0000 | 32'($urandom_range(0, 16'hFFFF));
         end
         mem_wready = 1'b0;
         if (ph == 2) begin
            if (wr_toggle) begin
               mem_wready = wtog;
               wtog = ~wtog;
            end else begin
               mem_wready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      last_grant = 1'b0;
   endtask

   // Model predicts the whole event stream, then requesters run back-to-back.
   task automatic run_jobs(input int ni, input int nd, output int first_done);
      int          il, dl, ij, dj, ii, di, wb, cyc, limit;
      bit          s, id, dd, dn, we;
      logic [31:0] a, ln;
      il = ni; dl = nd; ij = 0; dj = 0;
      while (il > 0 || dl > 0) begin
         if (il > 0 && dl > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
            s = ~last_grant;
`else
            s = 1'b1;
`endif
         end else begin
            s = (dl > 0);
         end
         last_grant = s;
         a  = s ? d_addr_a[dj] : i_addr_a[ij];
         ln = (a / (BL * 4)) * (BL * 4);
         we = s ? d_we_a[dj] : 1'b0;
         sb.push_back('{KIND_CMD, s, ln, we});
         for (int k = 0; k < BL; k++) begin
            if (we) sb.push_back('{KIND_WB, 1'b1, d_wd_a[dj][k], 1'b0});
            else    sb.push_back('{KIND_RB, s, rd_word(ln, k), 1'b0});
         end
         sb.push_back('{KIND_DONE, s, 32'h0, 1'b0});
         if (s) begin dj++; dl--; end else begin ij++; il--; end
      end

      @(posedge clk);
      #1;
      ii = 0; di = 0; wb = 0;
      i_req = (ni > 0);
      if (ni > 0) i_addr = i_addr_a[0];
      d_req = (nd > 0);
      if (nd > 0) begin
         d_addr = d_addr_a[0]; d_we = d_we_a[0]; d_wdata = d_wd_a[0][0];
      end
      first_done = -1; cyc = 0; limit = 80 * (ni + nd) + 20;
      while ((ii < ni || di < nd) && cyc < limit) begin
         @(negedge clk);
         id = i_done; dd = d_done; dn = d_wnext;
         if ((id || dd) && first_done < 0) first_done = cyc;
         @(posedge clk);
         #1;
         if (dn) begin
            wb++;
            if (wb < BL) d_wdata = d_wd_a[di][wb];
         end
         if (id) begin
            ii++;
            if (ii < ni) i_addr = i_addr_a[ii];
            else i_req = 1'b0;
         end
         if (dd) begin
            di++; wb = 0;
            if (di < nd) begin
               d_addr = d_addr_a[di]; d_we = d_we_a[di]; d_wdata = d_wd_a[di][0];
            end else begin
               d_req = 1'b0;
            end
         end
         cyc++;
      end
      if (ii < ni || di < nd) begin
         checks++; errors++;
         $display("FAIL run_timeout: got %0d of %0d transactions done, required all", ii + di, ni + nd);
         i_req = 1'b0; d_req = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      int fd;
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b1;
      i_addr = 32'hFFFF_FFFF; d_addr = 32'hFFFF_FFFF; d_wdata = 32'hCAFE_F00D;
      cmd_hold = 0; rnd_mode = 1'b0; wr_toggle = 1'b0; stray_en = 0; rd_xor = '0;
      last_grant = 1'b0;
      do_reset();

      // Reset state: everything quiet even with non-zero request-side inputs.
      @(negedge clk);
      chk("rst_cmd_valid", mem_cmd_valid, 0);
      chk("rst_cmd_we", mem_cmd_we, 0);
      chk("rst_cmd_addr", mem_cmd_addr, 0);
      chk("rst_wvalid", mem_wvalid, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_valids", {i_rvalid, d_rvalid, d_wnext, i_done, d_done}, 0);
      chk("rst_stall", stall, 0);

      // Single zero-wait I read.
      rd_xor = 32'h0000_1230 ^ 32'h0000_00A0;
      i_addr_a[0] = 32'h0000_1234;
      run_jobs(1, 0, fd);
      chk("i_read_done_cycle", fd, 6);

      // D write with toggling write-ready.
      wr_toggle = 1'b1;
      d_addr_a[0] = 32'h40; d_we_a[0] = 1'b1;
      d_wd_a[0][0] = 32'h11; d_wd_a[0][1] = 32'h22; d_wd_a[0][2] = 32'h33; d_wd_a[0][3] = 32'h44;
      run_jobs(0, 1, fd);
      chk("d_write_done_cycle", fd, 9);
      wr_toggle = 1'b0;

      // Simultaneous back-to-back streams from both sides.
      do_reset();
      rd_xor = 32'h5A5A_0000;
      for (int j = 0; j < 3; j++) begin
         i_addr_a[j] = 32'h1000 + 32'(j) * 32'h100;
         d_addr_a[j] = 32'h8000 + 32'(j) * 32'h100;
         d_we_a[j]   = 1'b0;
      end
      run_jobs(3, 3, fd);

      // Command stalled by the memory for five cycles.
      cmd_hold = 5;
      i_addr_a[0] = 32'h0000_2468;
      run_jobs(1, 0, fd);
      chk("cmd_hold_done_cycle", fd, 11);

      // Reset in the middle of a read burst, then stray read beats.
      @(posedge clk);
      #1;
      sb.push_back('{KIND_CMD, 1'b0, 32'h2000, 1'b0});
      sb.push_back('{KIND_RB, 1'b0, rd_word(32'h2000, 0), 1'b0});
      sb.push_back('{KIND_RB, 1'b0, rd_word(32'h2000, 1), 1'b0});
      i_addr = 32'h2000; i_req = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1; i_req = 1'b0; stray_en = 2;
      last_grant = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_valids", {i_rvalid, d_rvalid, d_wnext, i_done, d_done}, 0);
      chk("abort_cmd", {mem_cmd_valid, mem_cmd_we, mem_wvalid}, 0);
      chk("abort_addr", mem_cmd_addr, 0);
      chk("abort_stall", stall, 0);
      chk("rdata_passthru", i_rdata, mem_rdata);
      chk("abort_sb_drained", sb.size(), 0);
      stray_en = 1;
      i_addr_a[0] = 32'h0000_3000;
      run_jobs(1, 0, fd);
      chk("post_abort_done_cycle", fd, 6);

      // Randomised mixes of reads and writes with random memory handshakes.
      rnd_mode = 1'b1;
      for (int r = 0; r < 30; r++) begin
         int ni, nd;
         ni = $urandom_range(0, 2);
         nd = $urandom_range(0, 2);
         if (ni == 0 && nd == 0) ni = 1;
         rd_xor = $urandom;
         for (int j = 0; j < 2; j++) begin
            i_addr_a[j] = {1'b0, 31'($urandom)};
            d_addr_a[j] = {1'b1, 31'($urandom)};
            d_we_a[j]   = 1'($urandom_range(0, 1));
            for (int k = 0; k < BL; k++) d_wd_a[j][k] = $urandom;
         end
         run_jobs(ni, nd, fd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
